// File: rtl/ppu_trace_monitor.sv
// PPU trace monitor: snapshots PC_IF plus watched registers on every fetch-PC change,
// queues them, and streams tagged words; also dumps a data-RAM window as big-endian words.
module ppu_trace_monitor #(
  parameter int NCH   = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_if,
  input  logic [NCH*32-1:0] watch_regs,
  input  logic              dump_start,
  input  logic [AW-1:0]     dump_base,
  input  logic [7:0]        dump_words,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_tag,
  output logic [31:0]       out_data,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [15:0]       drop_cnt
);

  localparam int RW = (NCH + 1) * 32;
  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(NCH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACE = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_READ = 2'd1;
  localparam logic [1:0] D_HOLD = 2'd2;
  localparam logic [1:0] D_DONE = 2'd3;

  localparam logic [1:0] TAG_PC   = 2'b00;
  localparam logic [1:0] TAG_REG  = 2'b01;
  localparam logic [1:0] TAG_ADDR = 2'b10;
  localparam logic [1:0] TAG_DATA = 2'b11;

  // ---------------- capture and snapshot FIFO ----------------
  logic [31:0]   last_pc_q, last_pc_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   drop_q, drop_d;
  logic [RW-1:0] fifo_mem_q [DEPTH];
  logic [RW-1:0] head_rec;
  logic [31:0]   head_word [NCH+1];
  logic          fifo_empty, fifo_full, pc_change, push, pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pc_change  = (pc_if != last_pc_q);
  // Fullness is judged before any same-cycle pop, so a pop never rescues a push.
  assign push       = pc_change && !fifo_full;
  assign head_rec   = fifo_mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    for (int k = 0; k <= NCH; k++) head_word[k] = head_rec[32*k +: 32];
  end

  always_comb begin
    last_pc_d = pc_change ? pc_if : last_pc_q;
    wr_ptr_d  = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d  = rd_ptr_q + (PW+1)'(pop);
    drop_d    = drop_q;
    if (pc_change && fifo_full && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PW-1:0]] <= {watch_regs, pc_if};
  end

  // ---------------- dump engine ----------------
  logic [1:0]    dstate_q, dstate_d;
  logic [AW-1:0] word_addr_q, word_addr_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [7:0]    wcnt_nxt;
  logic [1:0]    rd_cnt_q, rd_cnt_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic [31:0]   dump_word_q, dump_word_d;
  logic          word_ready_q, word_ready_d;
  logic          dump_consume;

  assign mem_rd_en = (dstate_q == D_READ);
  assign mem_addr  = mem_rd_en ? (word_addr_q + AW'(rd_cnt_q)) : '0;
  assign dump_busy = (dstate_q != D_IDLE);
  assign dump_done = (dstate_q == D_DONE);
  assign wcnt_nxt  = wcnt_q + 8'd1;

  always_comb begin
    dstate_d     = dstate_q;
    word_addr_d  = word_addr_q;
    count_d      = count_q;
    wcnt_d       = wcnt_q;
    rd_cnt_d     = rd_cnt_q;
    rd_vld_d     = mem_rd_en;
    rd_last_d    = mem_rd_en && (rd_cnt_q == 2'd3);
    dump_word_d  = dump_word_q;
    word_ready_d = word_ready_q;
    // Bytes arrive one cycle after their strobe; shifting left lands byte 0 in [31:24].
    if (rd_vld_q)     dump_word_d  = {dump_word_q[23:0], mem_rdata};
    if (rd_last_q)    word_ready_d = 1'b1;
    if (dump_consume) word_ready_d = 1'b0;
    case (dstate_q)
      D_IDLE: begin
        if (dump_start) begin
          word_addr_d = dump_base;
          count_d     = dump_words;
          wcnt_d      = 8'd0;
          rd_cnt_d    = 2'd0;
          dstate_d    = (dump_words == 8'd0) ? D_DONE : D_READ;
        end
      end
      D_READ: begin
        rd_cnt_d = rd_cnt_q + 2'd1;
        if (rd_cnt_q == 2'd3) dstate_d = D_HOLD;
      end
      D_HOLD: begin
        if (dump_consume) begin
          word_addr_d = word_addr_q + AW'(4);
          wcnt_d      = wcnt_nxt;
          dstate_d    = (wcnt_nxt == count_q) ? D_DONE : D_READ;
        end
      end
      default: dstate_d = D_IDLE;
    endcase
  end

  // ---------------- output serializer ----------------
  logic [1:0]    ser_q, ser_d;
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic          dphase_q, dphase_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_tag_q, out_tag_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          accept;

  assign accept  = out_valid_q && out_ready;
  assign idx_nxt = idx_q + IW'(1);

  always_comb begin
    ser_d        = ser_q;
    idx_d        = idx_q;
    dphase_d     = dphase_q;
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_data_d   = out_data_q;
    pop          = 1'b0;
    dump_consume = 1'b0;
    case (ser_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          ser_d = S_TRACE;
          idx_d = '0;
        end else if (word_ready_q) begin
          ser_d    = S_DUMP;
          dphase_d = 1'b0;
        end
      end
      S_TRACE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_tag_d   = (idx_q == '0) ? TAG_PC : TAG_REG;
          out_data_d  = head_word[idx_q];
        end else if (accept) begin
          if (idx_q == LAST_IDX) begin
            pop         = 1'b1;
            out_valid_d = 1'b0;
            out_tag_d   = 2'b00;
            out_data_d  = 32'd0;
            idx_d       = '0;
            ser_d       = S_IDLE;
          end else begin
            idx_d      = idx_nxt;
            out_tag_d  = TAG_REG;
            out_data_d = head_word[idx_nxt];
          end
        end
      end
      S_DUMP: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_tag_d   = TAG_ADDR;
          out_data_d  = 32'(word_addr_q);
        end else if (accept) begin
          if (!dphase_q) begin
            dphase_d   = 1'b1;
            out_tag_d  = TAG_DATA;
            out_data_d = dump_word_q;
          end else begin
            dump_consume = 1'b1;
            out_valid_d  = 1'b0;
            out_tag_d    = 2'b00;
            out_data_d   = 32'd0;
            dphase_d     = 1'b0;
            ser_d        = S_IDLE;
          end
        end
      end
      default: ser_d = S_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q    <= 32'hFFFF_FFFF;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_q       <= 16'd0;
      dstate_q     <= D_IDLE;
      word_addr_q  <= '0;
      count_q      <= 8'd0;
      wcnt_q       <= 8'd0;
      rd_cnt_q     <= 2'd0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      dump_word_q  <= 32'd0;
      word_ready_q <= 1'b0;
      ser_q        <= S_IDLE;
      idx_q        <= '0;
      dphase_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_tag_q    <= 2'b00;
      out_data_q   <= 32'd0;
    end else begin
      last_pc_q    <= last_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_q       <= drop_d;
      dstate_q     <= dstate_d;
      word_addr_q  <= word_addr_d;
      count_q      <= count_d;
      wcnt_q       <= wcnt_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      dump_word_q  <= dump_word_d;
      word_ready_q <= word_ready_d;
      ser_q        <= ser_d;
      idx_q        <= idx_d;
      dphase_q     <= dphase_d;
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule
